csr_regfile: RTL and testbench

//   CSR storage and counter block for the pipelined RV32 core; consumer end of the CSR operand path.
//   The ALU computes the new CSR value and delivers it through the WB-stage write port.
//   The read port supplies the old CSR value to the EX-stage operand select and to rd writeback.

---
 rtl/csr_regfile.sv | 131 +++++++++++++
 tb/tb_csr_regfile.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - RV32 CSR bank with 64-bit cycle/instret counters and WB->EX bypass
// General R/W CSRs at GEN_BASE; counters readable at 0xCxx, writable through the 0xBxx aliases.
module csr_regfile #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 12,
  parameter int                NUM_GEN  = 16,
  parameter logic [ADDR_W-1:0] GEN_BASE = 12'h300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] csr_rd_addr,
  output logic [DATA_W-1:0] csr_rd_data,
  output logic              csr_rd_hit,
  input  logic              csr_wb_en,
  input  logic [ADDR_W-1:0] csr_wb_addr,
  input  logic [DATA_W-1:0] csr_wb_data,
  input  logic              retire_valid,
  output logic              csr_wb_ro_err
);

  localparam int                  IDX_W   = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1;
  localparam int                  CTR_W   = 2 * DATA_W;
  localparam logic [ADDR_W-1:0]   GEN_CNT = ADDR_W'(NUM_GEN);
  localparam logic [CTR_W-1:0]    CTR_ONE = CTR_W'(1);

  typedef enum logic [2:0] {
    CTR_NONE,
    CTR_CYC_LO,
    CTR_CYC_HI,
    CTR_INS_LO,
    CTR_INS_HI
  } ctr_sel_e;

  // Counter halves live at the same low byte in both the 0xC (RO) and 0xB (RW) pages.
  function automatic ctr_sel_e ctr_decode(input logic [ADDR_W-1:0] a);
    ctr_sel_e sel;
    sel = CTR_NONE;
    if (a[11:8] == 4'hC || a[11:8] == 4'hB) begin
      case (a[7:0])
        8'h00:   sel = CTR_CYC_LO;
        8'h80:   sel = CTR_CYC_HI;
        8'h02:   sel = CTR_INS_LO;
        8'h82:   sel = CTR_INS_HI;
        default: sel = CTR_NONE;
      endcase
    end
    return sel;
  endfunction

  logic [DATA_W-1:0] gen_q [NUM_GEN];
  logic [CTR_W-1:0]  cycle_q, cycle_nxt;
  logic [CTR_W-1:0]  instret_q, instret_nxt;
  logic              ro_err_q;

  logic [ADDR_W-1:0] rd_off, wb_off;
  logic              rd_is_gen, wb_is_gen;
  logic [IDX_W-1:0]  rd_idx, wb_idx;
  ctr_sel_e          rd_ctr, wb_ctr;
  logic              wb_is_c, wb_is_b, wb_err;

  // Offset subtraction wraps, so addresses below GEN_BASE fall outside the range too.
  assign rd_off    = csr_rd_addr - GEN_BASE;
  assign wb_off    = csr_wb_addr - GEN_BASE;
  assign rd_is_gen = rd_off < GEN_CNT;
  assign wb_is_gen = wb_off < GEN_CNT;
  assign rd_idx    = rd_off[IDX_W-1:0];
  assign wb_idx    = wb_off[IDX_W-1:0];
  assign rd_ctr    = ctr_decode(csr_rd_addr);
  assign wb_ctr    = ctr_decode(csr_wb_addr);
  assign wb_is_c   = csr_wb_addr[11:8] == 4'hC;
  assign wb_is_b   = csr_wb_addr[11:8] == 4'hB;
  assign wb_err    = csr_wb_en && (wb_is_c || (!wb_is_gen && wb_ctr == CTR_NONE));

  always_comb begin
    csr_rd_data = '0;
    csr_rd_hit  = 1'b0;
    if (rd_is_gen) begin
      csr_rd_hit = 1'b1;
      if (csr_wb_en && csr_wb_addr == csr_rd_addr) begin
        csr_rd_data = csr_wb_data;
      end else begin
        csr_rd_data = gen_q[rd_idx];
      end
    end else begin
      csr_rd_hit = rd_ctr != CTR_NONE;
      case (rd_ctr)
        CTR_CYC_LO: csr_rd_data = cycle_q[DATA_W-1:0];
        CTR_CYC_HI: csr_rd_data = cycle_q[CTR_W-1:DATA_W];
        CTR_INS_LO: csr_rd_data = instret_q[DATA_W-1:0];
        CTR_INS_HI: csr_rd_data = instret_q[CTR_W-1:DATA_W];
        default:    csr_rd_data = '0;
      endcase
    end
  end

  // A write through a 0xBxx alias replaces that counter's increment for the cycle.
  always_comb begin
    cycle_nxt   = cycle_q + CTR_ONE;
    instret_nxt = retire_valid ? instret_q + CTR_ONE : instret_q;
    if (csr_wb_en && wb_is_b) begin
      case (wb_ctr)
        CTR_CYC_LO: cycle_nxt   = {cycle_q[CTR_W-1:DATA_W], csr_wb_data};
        CTR_CYC_HI: cycle_nxt   = {csr_wb_data, cycle_q[DATA_W-1:0]};
        CTR_INS_LO: instret_nxt = {instret_q[CTR_W-1:DATA_W], csr_wb_data};
        CTR_INS_HI: instret_nxt = {csr_wb_data, instret_q[DATA_W-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GEN; i++) begin
        gen_q[i] <= '0;
      end
      cycle_q   <= '0;
      instret_q <= '0;
      ro_err_q  <= 1'b0;
    end else begin
      if (csr_wb_en && wb_is_gen) begin
        gen_q[wb_idx] <= csr_wb_data;
      end
      cycle_q   <= cycle_nxt;
      instret_q <= instret_nxt;
      ro_err_q  <= wb_err;
    end
  end

  assign csr_wb_ro_err = ro_err_q;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - scoreboard bench for csr_regfile
// Expectations are queued with the cycle they fall due and compared on the falling edge.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_hit;
  logic        csr_wb_en;
  logic [11:0] csr_wb_addr;
  logic [31:0] csr_wb_data;
  logic        retire_valid;
  logic        csr_wb_ro_err;

  always #5 clk = ~clk;

  csr_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .csr_rd_addr  (csr_rd_addr),
    .csr_rd_data  (csr_rd_data),
    .csr_rd_hit   (csr_rd_hit),
    .csr_wb_en    (csr_wb_en),
    .csr_wb_addr  (csr_wb_addr),
    .csr_wb_data  (csr_wb_data),
    .retire_valid (retire_valid),
    .csr_wb_ro_err(csr_wb_ro_err)
  );

  typedef struct {
    string       tag;
    int          kind;
    int          due;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [63:0] m_cycle     = '0;
  logic [63:0] m_instret   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int due, input logic [31:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.kind = kind;
    it.due  = due;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  // kind 0: rd_data, 1: rd_hit, 2: wb_ro_err
  task automatic drain();
    logic [31:0] obs;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        case (sb_q[i].kind)
          0:       obs = csr_rd_data;
          1:       obs = {31'b0, csr_rd_hit};
          default: obs = {31'b0, csr_wb_ro_err};
        endcase
        check(sb_q[i].tag, obs, sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_cycle   = '0;
      m_instret = '0;
    end else begin
      if (csr_wb_en && csr_wb_addr == 12'hB00)      m_cycle = {m_cycle[63:32], csr_wb_data};
      else if (csr_wb_en && csr_wb_addr == 12'hB80) m_cycle = {csr_wb_data, m_cycle[31:0]};
      else                                          m_cycle = m_cycle + 64'd1;
      if (csr_wb_en && csr_wb_addr == 12'hB02)      m_instret = {m_instret[63:32], csr_wb_data};
      else if (csr_wb_en && csr_wb_addr == 12'hB82) m_instret = {csr_wb_data, m_instret[31:0]};
      else if (retire_valid)                        m_instret = m_instret + 64'd1;
    end
  endtask

  task automatic cyc_end();
    @(negedge clk);
    drain();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                       input logic ret, input logic exp_err, input string tag);
    csr_wb_en    = we;
    csr_wb_addr  = wa;
    csr_wb_data  = wd;
    retire_valid = ret;
    push({tag, ".ro_err"}, 2, cyc + 1, {31'b0, exp_err});
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 12'h000, 32'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input logic hit, input string tag);
    csr_rd_addr = addr;
    push({tag, ".data"}, 0, cyc, exp);
    push({tag, ".hit"}, 1, cyc, {31'b0, hit});
  endtask

  // Reset held two edges while a general write and a retire are also requested.
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 12'h300, 32'hFFFF_FFFF, 1'b1, 1'b0, "rst_a");
    csr_rd_addr = 12'hC00;
    cyc_end();
    drive(1'b1, 12'h300, 32'hFFFF_FFFF, 1'b1, 1'b0, "rst_b");
    rd(12'hC02, 32'h0, 1'b1, "rst_instret");
    cyc_end();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    csr_rd_addr  = 12'h000;
    csr_wb_en    = 1'b0;
    csr_wb_addr  = 12'h000;
    csr_wb_data  = 32'h0;
    retire_valid = 1'b0;

    // T1 + T4: counters count from zero after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 12'h000, 32'h0, (i % 3) == 0, 1'b0, "t4_run");
      rd(12'hC00, 32'(i), 1'b1, "t4_cycle_run");
      cyc_end();
    end
    drive(1'b1, 12'hC00, 32'h55, 1'b0, 1'b1, "t4_wr_ro");
    rd(12'hC00, 32'd10, 1'b1, "t4_cycle");
    cyc_end();
    idle("t4_idle_a");
    rd(12'hC02, 32'd4, 1'b1, "t4_instret");
    cyc_end();
    idle("t4_idle_b");
    rd(12'hC00, 32'd12, 1'b1, "t4_ro_ignored");
    cyc_end();
    idle("t1_idle");
    rd(12'h300, 32'h0, 1'b1, "t1_gen_zero");
    cyc_end();

    // T2: general write/read and address-range edges
    drive(1'b1, 12'h300, 32'hDEAD_BEEF, 1'b0, 1'b0, "t2_wr");
    rd(12'h7C0, 32'h0, 1'b0, "t2_unimpl");
    cyc_end();
    idle("t2_idle_a");
    rd(12'h300, 32'hDEAD_BEEF, 1'b1, "t2_rd");
    cyc_end();
    idle("t2_idle_b");
    rd(12'h2FF, 32'h0, 1'b0, "t2_below");
    cyc_end();
    idle("t2_idle_c");
    rd(12'h310, 32'h0, 1'b0, "t2_above");
    cyc_end();

    // T3: bypass, no bypass for counters, top entry + retire, unimplemented write
    drive(1'b1, 12'h305, 32'h1234_5678, 1'b0, 1'b0, "t3_wr");
    rd(12'h305, 32'h1234_5678, 1'b1, "t3_bypass");
    cyc_end();
    idle("t3_idle_a");
    rd(12'h305, 32'h1234_5678, 1'b1, "t3_reg");
    cyc_end();
    drive(1'b1, 12'hC02, 32'hAAAA_5555, 1'b1, 1'b1, "t3_wr_c02");
    rd(12'hC02, m_instret[31:0], 1'b1, "t3_no_ctr_bypass");
    cyc_end();
    drive(1'b1, 12'h30F, 32'hCAFE_F00D, 1'b1, 1'b0, "t3_wr_top");
    rd(12'h30F, 32'hCAFE_F00D, 1'b1, "t3_top_bypass");
    cyc_end();
    drive(1'b1, 12'h7C0, 32'h1, 1'b0, 1'b1, "t3_wr_unimpl");
    rd(12'h30F, 32'hCAFE_F00D, 1'b1, "t3_top_reg");
    cyc_end();
    idle("t3_idle_b");
    rd(12'hC02, 32'd6, 1'b1, "t3_instret");
    cyc_end();

    // T5: 64-bit wrap through the alias writes
    drive(1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, "t5_wr_lo");
    rd(12'hB00, m_cycle[31:0], 1'b1, "t5_alias_lo");
    cyc_end();
    drive(1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b0, "t5_wr_hi");
    rd(12'hC00, 32'hFFFF_FFFF, 1'b1, "t5_lo_loaded");
    cyc_end();
    idle("t5_idle_a");
    rd(12'hC80, 32'hFFFF_FFFF, 1'b1, "t5_hi_loaded");
    cyc_end();
    idle("t5_idle_b");
    rd(12'hC00, 32'h0, 1'b1, "t5_wrap_lo");
    cyc_end();
    idle("t5_idle_c");
    rd(12'hB80, 32'h0, 1'b1, "t5_wrap_hi");
    cyc_end();

    // T6: instret write collides with retire
    drive(1'b1, 12'hB02, 32'h100, 1'b1, 1'b0, "t6_wr");
    rd(12'hC82, m_instret[63:32], 1'b1, "t6_hi_before");
    cyc_end();
    drive(1'b0, 12'h000, 32'h0, 1'b1, 1'b0, "t6_retire");
    rd(12'hC02, 32'h100, 1'b1, "t6_loaded");
    cyc_end();
    drive(1'b1, 12'hB82, 32'h7, 1'b1, 1'b0, "t6_wr_hi");
    rd(12'hC02, 32'h101, 1'b1, "t6_incr");
    cyc_end();
    idle("t6_idle_a");
    rd(12'hC82, 32'h7, 1'b1, "t6_hi");
    cyc_end();
    idle("t6_idle_b");
    rd(12'hC02, 32'h101, 1'b1, "t6_lo_held");
    cyc_end();

    // T1 again mid-run: reset beats the same-cycle write and retire
    do_reset();
    idle("t1b_idle_a");
    rd(12'hC00, 32'h0, 1'b1, "t1b_cycle");
    cyc_end();
    idle("t1b_idle_b");
    rd(12'h300, 32'h0, 1'b1, "t1b_gen300");
    cyc_end();
    idle("t1b_idle_c");
    rd(12'h305, 32'h0, 1'b1, "t1b_gen305");
    cyc_end();
    idle("t1b_idle_d");
    rd(12'hC02, m_instret[31:0], 1'b1, "t1b_instret");
    cyc_end();
    cyc_end();

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
